vending_machine_param: RTL
==========================

# vending_machine_param

Parametrised successor to the fixed two-coin vending FSM. It accepts three coin denominations, accumulates credit up to a configurable price, and pulses `sell` once per vend. Overpayment is returned as a stream of individual change coins over a valid/ready handshake, and a cancel input refunds all held credit. It sits between the coin-acceptor front end and the dispenser/change-hopper controllers.

## Interface
Parameters:
- `PRICE`, default 3: item price in credit units (1 unit = 0.5). Must be ≥1.
- `VAL1`, default 1: credit value of coin code 2'b01.
- `VAL2`, default 2: credit value of coin code 2'b10.
- `VAL3`, default 10: credit value of coin code 2'b11. Requires VAL1 < VAL2 < VAL3 and VAL1 = 1, so any remainder can be paid out.
- `CREDIT_W`, default 5: credit register width. Must hold PRICE−1+VAL3.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `coin`, in, 2: coin strobe, valid for one cycle. 00 means no coin.
- `cancel`, in, 1: one-cycle refund request.
- `coin_ready`, out, 1: high in IDLE and COLLECT.
- `coin_rej`, out, 1: combinational. Equals (coin≠0 && !coin_ready).
- `sell`, out, 1: one-cycle vend pulse.
- `chg_valid`, out, 1: a change coin is presented.
- `chg_coin`, out, 2: code of the presented change coin. 00 when chg_valid=0.
- `chg_ready`, in, 1: the hopper accepts the presented coin.

## Operation
- States are IDLE, COLLECT, VEND and CHANGE. The only registers are the state and `credit` (CREDIT_W bits).
- **IDLE** (credit=0)
  - A valid coin sets credit to its value.
  - Next state is VEND if the value ≥ PRICE, otherwise COLLECT.
  - cancel is ignored.
- **COLLECT**
  - A coin adds its value to credit. If the new credit ≥ PRICE, go to VEND.
  - cancel goes to CHANGE with the full credit as refund. No sell.
  - Coin and cancel in the same cycle: the coin is added first, then cancel takes priority over VEND. The refund is credit+value.
- **VEND**
  - sell=1 for this cycle only.
  - credit ← credit−PRICE.
  - Next state is CHANGE if the result is >0, otherwise IDLE.
- **CHANGE**
  - chg_valid=1. chg_coin is the largest denomination ≤ credit (greedy).
  - On chg_valid&&chg_ready: credit ← credit − that value. When the result is 0, go to IDLE.
  - While chg_ready=0, chg_coin and credit hold.
- In VEND and CHANGE, coins and cancel are ignored. The coin is flagged on coin_rej and credit is not modified.
- sell, chg_valid and chg_coin are decoded from registered state and credit only, with no combinational path from inputs. coin_rej is the only combinational output.

## Timing
- Reset: state=IDLE, credit=0. Outputs are sell=0, chg_valid=0, chg_coin=00, coin_ready=1, coin_rej=0 when coin=00.
- A reset asserted in any state, including mid-CHANGE with chg_valid=1, takes effect at the next edge and discards the remaining credit.
- Coin→sell latency: a coin completing the price at edge N gives sell high for exactly cycle N..N+1.
- Sell→first change coin: chg_valid rises on the cycle after sell.
- Throughput: with chg_ready held high, one change coin per cycle.
- Back-to-back purchases: IDLE is reached the cycle after the last change handshake, and coins are accepted from that cycle.

## Structure
- Shared package `vm_pkg`:
  - state enum
  - coin code constants COIN_NONE, COIN_1, COIN_2, COIN_3
- Sub-module `vm_change_sel`, purely combinational:
  - takes credit
  - returns the greedy coin code and its value
  - is parametrised on VAL1..VAL3 and CREDIT_W
- The top module holds the FSM, the credit arithmetic and output decode. Additions are done at CREDIT_W+1 bits for the ≥PRICE compare.

## Test plan
1. Coins 01,01,01 on consecutive cycles → sell pulses for one cycle after the third coin, chg_valid never rises, state returns to IDLE.
2. Coins 10,10 → credit 4, sell pulses, then one change coin 01 (credit 1), then IDLE.
3. Single coin 11 with chg_ready=1 → sell pulses, then change 10,10,10,01 on four consecutive cycles (7 units), then IDLE.
4. Coin 01, then cancel with chg_ready=0 for 3 cycles → chg_coin holds 01 for those cycles, then one handshake. sell is never asserted.
5. Coin 10 during CHANGE → coin_rej=1 that cycle and the change sequence is unaffected. Coin and cancel in the same COLLECT cycle → refund equals the old credit plus the coin value.
6. rst during CHANGE with chg_valid=1 → all outputs return to reset values on the next cycle, and a subsequent purchase behaves as in test 1.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the parametrised vending machine.
//   state_t   : FSM state encoding (IDLE, COLLECT, VEND, CHANGE)
//   COIN_*    : two-bit coin codes used on the coin strobe and change output
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

endpackage : vm_pkg

// File: rtl/vending_machine_param_if.sv
// Bus between the vending FSM, the coin-acceptor front end and the
// dispenser/change-hopper controllers.
//   coin       : coin strobe, one cycle, 00 = no coin
//   cancel     : one-cycle refund request
//   coin_ready : machine accepts coins this cycle
//   coin_rej   : presented coin is rejected (combinational)
//   sell       : one-cycle vend pulse
//   chg_valid  : a change coin is presented
//   chg_coin   : code of the presented change coin, 00 when idle
//   chg_ready  : hopper accepts the presented change coin
// Modports: slave = vending machine, master = the surrounding system.
interface vending_machine_param_if;

  logic [1:0] coin;
  logic       cancel;
  logic       coin_ready;
  logic       coin_rej;
  logic       sell;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       chg_ready;

  modport slave (
    input  coin, cancel, chg_ready,
    output coin_ready, coin_rej, sell, chg_valid, chg_coin
  );

  modport master (
    output coin, cancel, chg_ready,
    input  coin_ready, coin_rej, sell, chg_valid, chg_coin
  );

endinterface : vending_machine_param_if

// File: rtl/vm_change_sel.sv
// Greedy change selector, purely combinational.
//   i_credit : credit still owed
//   o_code   : largest coin code whose value is <= i_credit (00 if credit is 0)
//   o_value  : credit value of o_code
module vm_change_sel
  import vm_pkg::*;
#(
  parameter int unsigned VAL1     = 1,
  parameter int unsigned VAL2     = 2,
  parameter int unsigned VAL3     = 10,
  parameter int unsigned CREDIT_W = 5
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_code,
  output logic [CREDIT_W-1:0] o_value
);

  localparam logic [CREDIT_W-1:0] LP_V1 = CREDIT_W'(VAL1);
  localparam logic [CREDIT_W-1:0] LP_V2 = CREDIT_W'(VAL2);
  localparam logic [CREDIT_W-1:0] LP_V3 = CREDIT_W'(VAL3);

  always_comb begin
    o_code  = COIN_NONE;
    o_value = '0;
    if (i_credit >= LP_V3) begin
      o_code  = COIN_3;
      o_value = LP_V3;
    end else if (i_credit >= LP_V2) begin
      o_code  = COIN_2;
      o_value = LP_V2;
    end else if (i_credit >= LP_V1) begin
      o_code  = COIN_1;
      o_value = LP_V1;
    end
  end

endmodule : vm_change_sel

// File: rtl/vending_machine_param.sv
// Parametrised vending FSM: accumulates credit from three coin
// denominations, pulses sell once per vend, pays out overpayment or a
// cancelled credit as a stream of greedy change coins over valid/ready.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : vending_machine_param_if.slave (coin/cancel in, sell and change out)
// Registers are only the FSM state and the credit; sell/chg_* are decoded
// from them, coin_rej is the only combinational output.
module vending_machine_param
  import vm_pkg::*;
#(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned VAL1     = 1,
  parameter int unsigned VAL2     = 2,
  parameter int unsigned VAL3     = 10,
  parameter int unsigned CREDIT_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  vending_machine_param_if.slave        bus
);

  localparam logic [CREDIT_W-1:0] LP_V1      = CREDIT_W'(VAL1);
  localparam logic [CREDIT_W-1:0] LP_V2      = CREDIT_W'(VAL2);
  localparam logic [CREDIT_W-1:0] LP_V3      = CREDIT_W'(VAL3);
  localparam logic [CREDIT_W-1:0] LP_PRICE   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   LP_PRICE_X = (CREDIT_W + 1)'(PRICE);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;

  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_reach_price;
  logic [CREDIT_W-1:0] w_after_vend;
  logic [1:0]          w_chg_code;
  logic [CREDIT_W-1:0] w_chg_val;
  logic [CREDIT_W-1:0] w_after_chg;

  always_comb begin
    w_coin_val = '0;
    case (bus.coin)
      COIN_1:  w_coin_val = LP_V1;
      COIN_2:  w_coin_val = LP_V2;
      COIN_3:  w_coin_val = LP_V3;
      default: w_coin_val = '0;
    endcase
  end

  // One extra bit so the price compare cannot be fooled by wrap-around.
  // In IDLE the credit is zero, so the same sum serves both IDLE and COLLECT.
  assign w_sum         = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_reach_price = (w_sum >= LP_PRICE_X);
  assign w_after_vend  = r_credit - LP_PRICE;
  assign w_after_chg   = r_credit - w_chg_val;

  vm_change_sel #(
    .VAL1     (VAL1),
    .VAL2     (VAL2),
    .VAL3     (VAL3),
    .CREDIT_W (CREDIT_W)
  ) u_change_sel (
    .i_credit (r_credit),
    .o_code   (w_chg_code),
    .o_value  (w_chg_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.coin != COIN_NONE) begin
            r_credit <= w_sum[CREDIT_W-1:0];
            r_state  <= w_reach_price ? ST_VEND : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // The coin is added before cancel is considered, so a same-cycle
          // coin is part of the refund and cancel overrides VEND.
          r_credit <= w_sum[CREDIT_W-1:0];
          if (bus.cancel) begin
            r_state <= ST_CHANGE;
          end else if (w_reach_price) begin
            r_state <= ST_VEND;
          end
        end
        ST_VEND: begin
          r_credit <= w_after_vend;
          r_state  <= (w_after_vend != '0) ? ST_CHANGE : ST_IDLE;
        end
        ST_CHANGE: begin
          if (bus.chg_ready) begin
            r_credit <= w_after_chg;
            if (w_after_chg == '0) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_credit <= '0;
        end
      endcase
    end
  end

  assign bus.coin_ready = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign bus.coin_rej   = (bus.coin != COIN_NONE) && !bus.coin_ready;
  assign bus.sell       = (r_state == ST_VEND);
  assign bus.chg_valid  = (r_state == ST_CHANGE);
  assign bus.chg_coin   = (r_state == ST_CHANGE) ? w_chg_code : COIN_NONE;

endmodule : vending_machine_param
